// File: rtl/m_timer_countdown_if.sv
// Control and display bundle for the m_timer_countdown MM:SS BCD countdown timer.
// The master side drives the presets and command pulses; the slave side owns the digits and status outputs.
interface m_timer_countdown_if;
  logic       tick;
  logic       load;
  logic       start;
  logic       stop;
  logic [3:0] pre_min_t;
  logic [3:0] pre_min_o;
  logic [3:0] pre_sec_t;
  logic [3:0] pre_sec_o;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic       running;
  logic       alarm;
  logic       done_pulse;

  modport master (
    output tick, load, start, stop, pre_min_t, pre_min_o, pre_sec_t, pre_sec_o,
    input  min_t, min_o, sec_t, sec_o, running, alarm, done_pulse
  );

  modport slave (
    input  tick, load, start, stop, pre_min_t, pre_min_o, pre_sec_t, pre_sec_o,
    output min_t, min_o, sec_t, sec_o, running, alarm, done_pulse
  );
endinterface

// File: rtl/m_timer_countdown.sv
// MM:SS BCD countdown timer (IDLE/RUN/PAUSE/DONE) with a tick-timed alarm; all outputs are registered.
// Define TIMER_AUTORELOAD_EN to reload the preset on expiry instead of raising the alarm.
module m_timer_countdown #(
  parameter int ALARM_TICKS = 3
) (
  input logic                  clk,
  input logic                  rst,
  m_timer_countdown_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] ALARM_LIMIT = 4'(ALARM_TICKS);

  // Count is packed as {min_t, min_o, sec_t, sec_o}, one BCD digit per nibble.
  logic [1:0]  state_q, state_nx;
  logic [15:0] count_q, count_nx;
  logic [3:0]  alarm_cnt_q, alarm_cnt_nx;
  logic        done_nx;
  logic        running_q, alarm_q, done_q;
  logic [15:0] preset;
  logic [3:0]  alarm_inc;
  logic        reload_ok;
  logic [15:0] reload_val;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign preset = {clamp(bus.pre_min_t, 4'd9), clamp(bus.pre_min_o, 4'd9),
                   clamp(bus.pre_sec_t, 4'd5), clamp(bus.pre_sec_o, 4'd9)};

  assign alarm_inc = alarm_cnt_q + 4'd1;

`ifdef TIMER_AUTORELOAD_EN
  logic [15:0] shadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= 16'h0000;
    end else if (bus.load) begin
      shadow_q <= preset;
    end
  end

  // A zero shadow cannot be reloaded, so expiry then falls back to the alarm path.
  assign reload_ok  = (shadow_q != 16'h0000);
  assign reload_val = shadow_q;
`else
  assign reload_ok  = 1'b0;
  assign reload_val = 16'h0000;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx     = state_q;
    count_nx     = count_q;
    alarm_cnt_nx = alarm_cnt_q;
    done_nx      = 1'b0;
    if (bus.load) begin
      count_nx     = preset;
      alarm_cnt_nx = 4'd0;
      state_nx     = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (bus.start && (count_q != 16'h0000)) state_nx = S_RUN;
        end
        S_RUN: begin
          if (bus.stop) begin
            state_nx = S_PAUSE;
          end else if (bus.tick) begin
            if (count_q == 16'h0001) begin
              done_nx = 1'b1;
              if (reload_ok) begin
                count_nx = reload_val;
              end else begin
                count_nx     = 16'h0000;
                alarm_cnt_nx = 4'd0;
                state_nx     = S_DONE;
              end
            end else begin
              count_nx = bcd_dec(count_q);
            end
          end
        end
        default: begin
          if (bus.stop) begin
            alarm_cnt_nx = 4'd0;
            state_nx     = S_IDLE;
          end else if (bus.tick) begin
            if (alarm_inc >= ALARM_LIMIT) begin
              alarm_cnt_nx = 4'd0;
              state_nx     = S_IDLE;
            end else begin
              alarm_cnt_nx = alarm_inc;
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= 16'h0000;
      alarm_cnt_q <= 4'd0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_nx;
      count_q     <= count_nx;
      alarm_cnt_q <= alarm_cnt_nx;
      running_q   <= (state_nx == S_RUN);
      alarm_q     <= (state_nx == S_DONE);
      done_q      <= done_nx;
    end
  end

  assign bus.min_t      = count_q[15:12];
  assign bus.min_o      = count_q[11:8];
  assign bus.sec_t      = count_q[7:4];
  assign bus.sec_o      = count_q[3:0];
  assign bus.running    = running_q;
  assign bus.alarm      = alarm_q;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_m_timer_countdown.sv
// Directed bench for m_timer_countdown: each step queues its expected outputs and they are checked after the edge.
// Covers the default build, or the reload behaviour when TIMER_AUTORELOAD_EN is defined.
module tb_m_timer_countdown;

  typedef struct {
    string       tag;
    logic [15:0] count;
    logic        running;
    logic        alarm;
    logic        done;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  m_timer_countdown_if bus ();

  m_timer_countdown #(.ALARM_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic compare_head();
    exp_t        e;
    logic [15:0] obs;
    e   = sb.pop_front();
    obs = {bus.min_t, bus.min_o, bus.sec_t, bus.sec_o};
    checks++;
    assert (obs === e.count) else begin
      failures++;
      $error("FAIL %s count observed=%h expected=%h", e.tag, obs, e.count);
    end
    checks++;
    assert (bus.running === e.running) else begin
      failures++;
      $error("FAIL %s running observed=%b expected=%b", e.tag, bus.running, e.running);
    end
    checks++;
    assert (bus.alarm === e.alarm) else begin
      failures++;
      $error("FAIL %s alarm observed=%b expected=%b", e.tag, bus.alarm, e.alarm);
    end
    checks++;
    assert (bus.done_pulse === e.done) else begin
      failures++;
      $error("FAIL %s done_pulse observed=%b expected=%b", e.tag, bus.done_pulse, e.done);
    end
  endtask

  // Drive one edge's worth of stimulus, queue what it must produce, then check after the edge.
  task automatic step(input string tag, input logic r, input logic l, input logic s,
                      input logic p, input logic t, input logic [15:0] pre,
                      input logic [15:0] e_cnt, input logic e_run, input logic e_alm,
                      input logic e_done);
    exp_t e;
    @(negedge clk);
    rst       = r;
    bus.load  = l;
    bus.start = s;
    bus.stop  = p;
    bus.tick  = t;
    {bus.pre_min_t, bus.pre_min_o, bus.pre_sec_t, bus.pre_sec_o} = pre;
    e.tag = tag; e.count = e_cnt; e.running = e_run; e.alarm = e_alm; e.done = e_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
    compare_head();
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
    {bus.pre_min_t, bus.pre_min_o, bus.pre_sec_t, bus.pre_sec_o} = 16'h0000;

    //     tag              rst  ld   st   sp   tk   preset    count     run  alm  done
    step("reset",          1'b1,1'b0,1'b0,1'b0,1'b0,16'h1234, 16'h0000, 1'b0,1'b0,1'b0);

`ifdef TIMER_AUTORELOAD_EN
    step("ar_load",        1'b0,1'b1,1'b0,1'b0,1'b0,16'h0002, 16'h0002, 1'b0,1'b0,1'b0);
    step("ar_start",       1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0002, 1'b1,1'b0,1'b0);
    step("ar_tick1",       1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0001, 1'b1,1'b0,1'b0);
    step("ar_reload",      1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0002, 1'b1,1'b0,1'b1);
    step("ar_pulse_end",   1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0002, 1'b1,1'b0,1'b0);
    step("ar_tick2",       1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0001, 1'b1,1'b0,1'b0);
    step("ar_rst_mid_run", 1'b1,1'b1,1'b0,1'b0,1'b1,16'h0300, 16'h0000, 1'b0,1'b0,1'b0);
`else
    step("load_0003",      1'b0,1'b1,1'b0,1'b0,1'b0,16'h0003, 16'h0003, 1'b0,1'b0,1'b0);
    step("start",          1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0003, 1'b1,1'b0,1'b0);
    step("tick_0002",      1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0002, 1'b1,1'b0,1'b0);
    step("tick_0001",      1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0001, 1'b1,1'b0,1'b0);
    step("expire",         1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b0,1'b1,1'b1);
    step("pulse_end",      1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0000, 1'b0,1'b1,1'b0);
    step("start_in_done",  1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0000, 1'b0,1'b1,1'b0);
    step("alarm_tick1",    1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b0,1'b1,1'b0);
    step("alarm_tick2",    1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b0,1'b1,1'b0);
    step("alarm_tick3",    1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b0,1'b0,1'b0);
    step("start_at_zero",  1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0000, 1'b0,1'b0,1'b0);
    step("load_0001",      1'b0,1'b1,1'b0,1'b0,1'b0,16'h0001, 16'h0001, 1'b0,1'b0,1'b0);
    step("start_0001",     1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0001, 1'b1,1'b0,1'b0);
    step("expire_again",   1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b0,1'b1,1'b1);
    step("stop_in_done",   1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000, 16'h0000, 1'b0,1'b0,0);
    step("tick_in_idle",   1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b0,1'b0,1'b0);
    step("load_0001_b",    1'b0,1'b1,1'b0,1'b0,1'b0,16'h0001, 16'h0001, 1'b0,1'b0,1'b0);
    step("start_b",        1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0001, 1'b1,1'b0,1'b0);
    step("expire_b",       1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0000, 1'b0,1'b1,1'b1);
    step("load_in_done",   1'b0,1'b1,1'b0,1'b0,1'b1,16'h0002, 16'h0002, 1'b0,1'b0,1'b0);
`endif

    step("load_1000",      1'b0,1'b1,1'b0,1'b0,1'b0,16'h1000, 16'h1000, 1'b0,1'b0,1'b0);
    step("start_1000",     1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h1000, 1'b1,1'b0,1'b0);
    step("borrow_0959",    1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0959, 1'b1,1'b0,1'b0);
    step("load_0100_run",  1'b0,1'b1,1'b0,1'b1,1'b1,16'h0100, 16'h0100, 1'b0,1'b0,1'b0);
    step("start_0100",     1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0100, 1'b1,1'b0,1'b0);
    step("borrow_0059",    1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0059, 1'b1,1'b0,1'b0);
    step("load_2000",      1'b0,1'b1,1'b0,1'b0,1'b0,16'h2000, 16'h2000, 1'b0,1'b0,1'b0);
    step("start_2000",     1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h2000, 1'b1,1'b0,1'b0);
    step("borrow_1959",    1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h1959, 1'b1,1'b0,1'b0);
    step("clamp_AF7C",     1'b0,1'b1,1'b0,1'b0,1'b0,16'hAF7C, 16'h9959, 1'b0,1'b0,1'b0);
    step("stop_in_idle",   1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000, 16'h9959, 1'b0,1'b0,1'b0);
    step("load_0005",      1'b0,1'b1,1'b0,1'b0,1'b0,16'h0005, 16'h0005, 1'b0,1'b0,1'b0);
    step("start_0005",     1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0005, 1'b1,1'b0,1'b0);
    step("stop_with_tick", 1'b0,1'b0,1'b0,1'b1,1'b1,16'h0000, 16'h0005, 1'b0,1'b0,1'b0);
    step("pause_tick1",    1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0005, 1'b0,1'b0,1'b0);
    step("pause_tick2",    1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0005, 1'b0,1'b0,1'b0);
    step("resume_w_tick",  1'b0,1'b0,1'b1,1'b0,1'b1,16'h0000, 16'h0005, 1'b1,1'b0,1'b0);
    step("tick_0004",      1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000, 16'h0004, 1'b1,1'b0,1'b0);
    step("stop_beats_start",1'b0,1'b0,1'b1,1'b1,1'b1,16'h0000,16'h0004, 1'b0,1'b0,1'b0);
    step("resume",         1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000, 16'h0004, 1'b1,1'b0,1'b0);
    step("rst_mid_run",    1'b1,1'b1,1'b1,1'b1,1'b1,16'h0300, 16'h0000, 1'b0,1'b0,1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
